axis_frame_arb_mux: RTL and testbench
=====================================

Name: axis_frame_arb_mux

Overview:
- Frame-granular round-robin arbiter and multiplexer that shares the single s-side input of the async FIFO/width-adapter path among S_COUNT AXI-Stream requesters, for example several packet builders feeding one Ethernet TX FIFO.
- Once a source is granted, it keeps the output until it completes a beat with tlast, so frames are never interleaved.
- The source index is emitted on m_axis_tid so downstream logic can demultiplex.

Parameters:
S_COUNT, 4, number of input streams (2..16)
DATA_WIDTH, 8, tdata width per stream
USER_WIDTH, 1, tuser width per stream
ID_WIDTH, $clog2(S_COUNT), width of m_axis_tid / grant_index
UPDATE_TID, 1, 1 = drive m_axis_tid with granted index; 0 = drive it with 0

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  reset, synchronous, active-low
s_axis_tdata  in  S_COUNT*DATA_WIDTH  concatenated input data, stream i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  S_COUNT  per-stream valid
s_axis_tready  out  S_COUNT  per-stream ready
s_axis_tlast  in  S_COUNT  per-stream end of frame
s_axis_tuser  in  S_COUNT*USER_WIDTH  per-stream user sideband
m_axis_tdata  out  DATA_WIDTH  muxed data (registered)
m_axis_tvalid  out  1  output valid (registered)
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  muxed tlast (registered)
m_axis_tuser  out  USER_WIDTH  muxed tuser (registered)
m_axis_tid  out  ID_WIDTH  source index of current beat (registered)
grant_valid  out  1  a frame is currently granted
grant_index  out  ID_WIDTH  index of the granted source
frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted from the source

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: m_axis_tvalid=0, m_axis_tdata/tlast/tuser/tid=0, s_axis_tready=0, grant_valid=0, grant_index=0, frame_done=0, state=IDLE, rr_ptr=0.
- Reset mid-frame: the partial frame is dropped without a tlast beat, and the output register is invalidated on the same edge.
- Output stage: a single register. out_accept = !m_axis_tvalid || m_axis_tready.
- s_axis_tready[i] = (state==ACTIVE) && grant_index==i && out_accept. All other bits are 0.
- Source beat accepted when s_axis_tvalid[g] && s_axis_tready[g]. On that edge the beat is loaded into the output register: m_axis_tvalid=1, tid=g (or 0 if UPDATE_TID=0).
- If m_axis_tready=1 and no beat is loaded, m_axis_tvalid clears.
- Output data is held stable while m_axis_tvalid && !m_axis_tready.
- Latency: 1 cycle from source acceptance to m_axis_tvalid. Throughput is 1 beat/cycle within a frame.
- State machine:
  - IDLE: if any s_axis_tvalid is set, choose the first requester at or cyclically after rr_ptr (search rr_ptr, rr_ptr+1, ..., wrapping modulo S_COUNT). Register grant_index=choice and grant_valid=1, then go to ACTIVE. No beat is accepted in the arbitration cycle. If no requests, stay in IDLE.
  - ACTIVE: accept beats from the granted source. On accepting a beat with tlast=1: frame_done=1 for 1 cycle, grant_valid=0, rr_ptr=(grant_index+1) mod S_COUNT, go to IDLE.
  - ACTIVE, granted source drops tvalid mid-frame: the grant is held indefinitely, with no preemption and no timeout.
- Minimum gap: 1 idle cycle on the source side between consecutive frames. The output may still be draining the previous last beat during this cycle.
- Simultaneous events:
  - tlast accepted while other requests are pending: the next grant is chosen in the following IDLE cycle using the updated rr_ptr.
  - Output stalled (m_axis_tready=0 with a valid beat): s_axis_tready=0, so no overwrite is possible.
- Single-beat frames (tvalid and tlast in the same beat) are legal. They cost 2 cycles per frame on the source side.
- Requester order within a search: lower index wins only as a tie-break relative to rr_ptr. Starvation-free: any persistently requesting source is granted within S_COUNT frames.
- S_COUNT that is not a power of two: the rr_ptr wrap is explicit (S_COUNT-1 -> 0), and indices >= S_COUNT are never granted.

Test Plan:
1. Single source: stream 2 sends 3-beat frame 0xA1,0xA2,0xA3(tlast), m_axis_tready=1 -> grant_index=2 one cycle after tvalid. The beats appear on m_axis at consecutive cycles with tid=2, tlast on 0xA3. frame_done pulses once.
2. All 4 sources request continuously with 2-beat frames -> output frames arrive in tid order 0,1,2,3,0,... with no interleaving within a frame. There is exactly 1 bubble cycle between frames on the source side.
3. Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat frame from source 1 -> no beat lost or duplicated. m_axis_tdata is stable while stalled. s_axis_tready[1]=0 while the output is valid and not ready.
4. Round-robin fairness: rr_ptr=3 after a source-2 frame, sources 0 and 3 request -> source 3 is granted first, then source 0.
5. Mid-frame gap: source 0 deasserts tvalid for 5 cycles inside a frame while source 1 requests -> grant stays 0, source 1 sees tready=0 throughout, and source 1 is granted only after source 0's tlast.
6. Reset mid-frame: rst_n=0 for 1 cycle during beat 2 of 4 -> next cycle m_axis_tvalid=0, grant_valid=0, all s_axis_tready=0. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/axis_frame_arb_mux.sv
// Frame-granular round-robin arbiter/mux: S_COUNT AXI-Stream sources share one
// registered output. A granted source keeps the output until its tlast beat is
// accepted, so frames never interleave; the source index rides on m_axis_tid.
module axis_frame_arb_mux #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(S_COUNT),
    parameter bit UPDATE_TID = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_index,
    output logic                          frame_done
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_grant_index;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic                  r_grant_valid;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [USER_WIDTH-1:0] r_m_tuser;
    logic [ID_WIDTH-1:0]   r_m_tid;

    logic                  w_out_accept;
    logic                  w_beat_accept;
    logic                  w_req_found;
    logic [S_COUNT-1:0]    w_rot;
    logic [ID_WIDTH-1:0]   w_off;
    logic [ID_WIDTH:0]     w_sum;
    logic [ID_WIDTH-1:0]   w_choice;
    logic [ID_WIDTH-1:0]   w_next_ptr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [USER_WIDTH-1:0] w_sel_user;

    // Output register can take a new beat when empty or draining this cycle.
    assign w_out_accept  = !r_m_tvalid || m_axis_tready;
    assign w_beat_accept = (r_state == ACTIVE) && w_out_accept && w_sel_valid;

    // Requests rotated so bit 0 is the rr_ptr position; first set bit wins.
    assign w_rot       = S_COUNT'({s_axis_tvalid, s_axis_tvalid} >> r_rr_ptr);
    assign w_req_found = |s_axis_tvalid;

    // Priority encode rotated requests, then map offset back to a source index.
    always_comb begin
        w_off = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = ID_WIDTH'(k);
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (ID_WIDTH + 1)'(S_COUNT)) w_sum = w_sum - (ID_WIDTH + 1)'(S_COUNT);
        w_choice = ID_WIDTH'(w_sum);
    end

    // Explicit wrap keeps non-power-of-two S_COUNT from reaching unused indices.
    assign w_next_ptr = (r_grant_index == ID_WIDTH'(S_COUNT - 1)) ? '0
                                                                  : r_grant_index + ID_WIDTH'(1);

    // Mux the granted source's beat.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_user  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (r_grant_index == ID_WIDTH'(i)) begin
                w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < S_COUNT; gi++) begin : g_rdy
            assign s_axis_tready[gi] = (r_state == ACTIVE) &&
                                       (r_grant_index == ID_WIDTH'(gi)) && w_out_accept;
        end
    endgenerate

    // Grant FSM: arbitrate in IDLE, hold the grant until the tlast beat is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant_index <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_found) begin
                        r_grant_index <= w_choice;
                        r_grant_valid <= 1'b1;
                        r_state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_beat_accept && w_sel_last) begin
                        r_frame_done  <= 1'b1;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register: load on source accept, clear when drained with nothing new.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
            r_m_tid    <= '0;
        end else if (w_beat_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_data;
            r_m_tlast  <= w_sel_last;
            r_m_tuser  <= w_sel_user;
            r_m_tid    <= UPDATE_TID ? r_grant_index : '0;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tid    = r_m_tid;
    assign grant_valid   = r_grant_valid;
    assign grant_index   = r_grant_index;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// Directed bench for axis_frame_arb_mux: per-source beat queues drive the inputs,
// an expected-beat scoreboard is popped on every output handshake.
module tb_axis_frame_arb_mux;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tready;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic [1:0]  m_axis_tid;
    logic        grant_valid;
    logic [1:0]  grant_index;
    logic        frame_done;

    axis_frame_arb_mux #(.S_COUNT(4), .DATA_WIDTH(8), .USER_WIDTH(1), .ID_WIDTH(2), .UPDATE_TID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
        .grant_valid(grant_valid), .grant_index(grant_index), .frame_done(frame_done)
    );

    typedef struct packed {logic [7:0] data; logic last; logic [3:0] gap;} beat_t;
    typedef struct packed {logic [7:0] data; logic last; logic [1:0] tid;} exp_t;

    beat_t src_q[S][$];
    exp_t  exp_q[$];
    int    out_cyc[$];
    logic [3:0] take;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    fd_cnt = 0;
    logic       prev_stall;
    logic [7:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one frame for a source and its expected output beats.
    task automatic push_frame(input int src, input logic [7:0] base, input int n, input int gap_at, input logic [3:0] gap);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            b.data = base + 8'(k);
            b.last = (k == n - 1);
            b.gap  = (k == gap_at) ? gap : 4'd0;
            src_q[src].push_back(b);
            e.data = b.data;
            e.last = b.last;
            e.tid  = 2'(src);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
                src_q[2].size() != 0 || src_q[3].size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Source drivers plus output monitor, driven at negedge and sampled just before posedge.
    initial begin
        take = '0;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < S; i++) begin
                if (take[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                take[i] = 1'b0;
            end
            for (int i = 0; i < S; i++) begin
                if (src_q[i].size() != 0 && src_q[i][0].gap != 0) begin
                    beat_t b;
                    b = src_q[i][0];
                    b.gap = b.gap - 4'd1;
                    src_q[i][0] = b;
                    s_axis_tvalid[i] = 1'b0;
                end else if (src_q[i].size() != 0) begin
                    s_axis_tvalid[i] = 1'b1;
                    s_axis_tdata[i*8 +: 8] = src_q[i][0].data;
                    s_axis_tlast[i] = src_q[i][0].last;
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i] = 1'b0;
                end
            end
            #4;
            for (int i = 0; i < S; i++) take[i] = rst_n && s_axis_tvalid[i] && s_axis_tready[i];
            if (rst_n && frame_done) fd_cnt++;
            if (rst_n && m_axis_tvalid) begin
                if (prev_stall) chk("stall_data_stable", 32'(m_axis_tdata), 32'(prev_data));
                if (!m_axis_tready) chk("stall_s_tready", 32'(s_axis_tready), 32'd0);
                if (m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $error("FAIL unexpected_beat: observed %0h expected none", m_axis_tdata);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checks--;
                        chk("out_beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tid}), 32'({e.data, e.last, e.tid}));
                        out_cyc.push_back(cyc);
                    end
                end
            end
            prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    initial begin
        logic [3:0] pat;
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        s_axis_tlast = '0;
        s_axis_tuser = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", 32'({m_axis_tdata, m_axis_tlast, m_axis_tid}), 32'd0);
        chk("rst_grant", 32'({grant_valid, grant_index}), 32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // 1: single 3-beat frame from source 2
        @(posedge clk); #1;
        out_cyc.delete(); fd_cnt = 0;
        push_frame(2, 8'hA1, 3, -1, 4'd0);
        @(negedge clk); #1;
        chk("t1_no_grant_yet", 32'(grant_valid), 32'd0);
        @(negedge clk); #1;
        chk("t1_grant", 32'({grant_valid, grant_index}), 32'({1'b1, 2'd2}));
        chk("t1_s_tready", 32'(s_axis_tready), 32'b0100);
        wait_drain("t1_drain");
        chk("t1_beats_back_to_back", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        chk("t1_frame_done", 32'(fd_cnt), 32'd1);

        // 2: all sources, two 2-beat frames each; rr_ptr=3 so order 3,0,1,2,3,0,1,2
        @(posedge clk); #1;
        out_cyc.delete(); fd_cnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < S; k++) begin
                int s;
                s = (3 + k) % S;
                push_frame(s, 8'((s << 4) | (r << 2)), 2, -1, 4'd0);
            end
        end
        wait_drain("t2_drain");
        chk("t2_beat_count", 32'(out_cyc.size()), 32'd16);
        chk("t2_span_one_bubble", 32'(out_cyc[15] - out_cyc[0]), 32'd22);
        chk("t2_frame_done", 32'(fd_cnt), 32'd8);

        // 3: backpressure on a 4-beat frame from source 1
        @(posedge clk); #1;
        push_frame(1, 8'hB0, 4, -1, 4'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t3_grant", 32'({grant_valid, grant_index}), 32'({1'b1, 2'd1}));
        pat = 4'b1001;
        for (int k = 0; k < 12; k++) begin
            m_axis_tready = pat[3 - (k % 4)];
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        wait_drain("t3_drain");

        // 4: source 2 single-beat frame leaves rr_ptr=3; then 0 and 3 contend
        @(posedge clk); #1;
        push_frame(2, 8'hC0, 1, -1, 4'd0);
        wait_drain("t4a_drain");
        @(posedge clk); #1;
        push_frame(3, 8'hD3, 2, -1, 4'd0);
        push_frame(0, 8'hD0, 2, -1, 4'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t4_grant_3_first", 32'({grant_valid, grant_index}), 32'({1'b1, 2'd3}));
        wait_drain("t4_drain");

        // 5: source 0 stalls 5 cycles mid-frame while source 1 waits
        @(posedge clk); #1;
        push_frame(0, 8'h50, 4, 2, 4'd5);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t5_grant0", 32'({grant_valid, grant_index}), 32'({1'b1, 2'd0}));
        push_frame(1, 8'h70, 2, -1, 4'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("t5_hold_grant0", 32'({grant_valid, grant_index}), 32'({1'b1, 2'd0}));
            chk("t5_src1_not_ready", 32'(s_axis_tready[1]), 32'd0);
        end
        wait_drain("t5_drain");

        // 6: reset during beat 2 of 4; arbitration then restarts at rr_ptr=0
        @(posedge clk); #1;
        begin
            beat_t b;
            for (int k = 0; k < 4; k++) begin
                b.data = 8'h60 + 8'(k);
                b.last = (k == 3);
                b.gap  = 4'd0;
                src_q[0].push_back(b);
            end
        end
        begin
            int n = 0;
            do begin
                @(negedge clk); #2;
                n++;
            end while (src_q[0].size() != 3 && n < 50);
            chk("t6_first_beat_taken", 32'(n < 50), 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t6_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("t6_rst_s_tready", 32'(s_axis_tready), 32'd0);
        rst_n = 1'b1;
        src_q[0].delete();
        s_axis_tvalid[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        push_frame(1, 8'h81, 2, -1, 4'd0);
        push_frame(3, 8'h83, 2, -1, 4'd0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t6_restart_grant1", 32'({grant_valid, grant_index}), 32'({1'b1, 2'd1}));
        wait_drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
